// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: RAM handshake status, arbiter FSM states, word type.
package ram_arb_pkg;
  localparam int WORD_W_DEF = 32;

  typedef logic [WORD_W_DEF-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;
endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_picker #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          grant_valid,
  output logic [PW-1:0] grant
);
  logic [PW-1:0] idx;

  // Scan from the farthest candidate back to ptr so the nearest one wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter for CPUS cores: data beats instruction, round-robin within
// each class, one transaction in flight, all requester-facing outputs registered.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS*WORD_W-1:0] iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);
  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t      state, state_n;
  ramstate_t       rs;
  logic [PW-1:0]   dptr, iptr, win, win_nxt, dg, ig, sel;
  logic            win_d, dg_v, ig_v, win_req;
  logic            grant, access, abort, done;
  logic [CPUS-1:0] dreq;
  logic [WORD_W-1:0] ia [CPUS];
  logic [WORD_W-1:0] da [CPUS];
  logic [WORD_W-1:0] ds [CPUS];
  logic [WORD_W-1:0] il [CPUS];
  logic [WORD_W-1:0] dl [CPUS];

  assign rs   = ramstate_t'(ramstate);
  assign dreq = dREN | dWEN;

  generate
    for (genvar k = 0; k < CPUS; k++) begin : g_lane
      assign ia[k] = iaddr[k*WORD_W +: WORD_W];
      assign da[k] = daddr[k*WORD_W +: WORD_W];
      assign ds[k] = dstore[k*WORD_W +: WORD_W];
      assign iload[k*WORD_W +: WORD_W] = il[k];
      assign dload[k*WORD_W +: WORD_W] = dl[k];
    end
  endgenerate

  rr_picker #(.N(CPUS)) u_dpick (.req(dreq), .ptr(dptr), .grant_valid(dg_v), .grant(dg));
  rr_picker #(.N(CPUS)) u_ipick (.req(iREN), .ptr(iptr), .grant_valid(ig_v), .grant(ig));

  assign sel     = dg_v ? dg : ig;
  assign win_req = win_d ? dreq[win] : iREN[win];
  assign win_nxt = (win == PW'(CPUS - 1)) ? '0 : win + PW'(1);

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    access  = 1'b0;
    abort   = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (dg_v || ig_v) begin
        state_n = REQ;
        grant   = 1'b1;
      end
      // A vanished request wins over a same-cycle ACCESS: nobody is left to receive it.
      REQ: if (!win_req) begin
        state_n = IDLE;
        abort   = 1'b1;
      end else if (rs == ACCESS) begin
        state_n = RESP;
        access  = 1'b1;
      end
      RESP: begin
        state_n = IDLE;
        done    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      win      <= '0;
      win_d    <= 1'b0;
      dptr     <= '0;
      iptr     <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      iwait    <= '1;
      dwait    <= '1;
      for (int k = 0; k < CPUS; k++) begin
        il[k] <= '0;
        dl[k] <= '0;
      end
    end else begin
      state <= state_n;
      if (grant) begin
        win   <= sel;
        win_d <= dg_v;
        if (dg_v) begin
          ramWEN   <= dWEN[dg];
          ramREN   <= ~dWEN[dg];
          ramaddr  <= da[dg];
          ramstore <= dWEN[dg] ? ds[dg] : '0;
        end else begin
          ramWEN   <= 1'b0;
          ramREN   <= 1'b1;
          ramaddr  <= ia[ig];
          ramstore <= '0;
        end
      end
      if (abort || access) begin
        ramREN <= 1'b0;
        ramWEN <= 1'b0;
      end
      // Wait goes low together with entry to RESP so it is visible for exactly that cycle.
      if (access) begin
        if (win_d) begin
          dwait[win] <= 1'b0;
          dl[win]    <= ramWEN ? '0 : ramload;
        end else begin
          iwait[win] <= 1'b0;
          il[win]    <= ramload;
        end
      end
      if (done) begin
        iwait <= '1;
        dwait <= '1;
        for (int k = 0; k < CPUS; k++) begin
          il[k] <= '0;
          dl[k] <= '0;
        end
        if (win_d) dptr <= win_nxt;
        else       iptr <= win_nxt;
      end
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed scenarios followed by a randomized run scored against a transaction-level model.
module tb_ram_arbiter;
  import ram_arb_pkg::*;
  localparam int CPUS = 2;
  localparam int W    = 32;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [CPUS-1:0] iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS*W-1:0] iaddr, iload, daddr, dstore, dload;
  logic            ramREN, ramWEN;
  logic [W-1:0]    ramaddr, ramstore, ramload;
  logic [1:0]      ramstate;

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  word_t mem [word_t];

  ram_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge CLK);
  endtask

  function automatic logic [W-1:0] fld(input logic [CPUS*W-1:0] v, input int k);
    return v[k*W +: W];
  endfunction

  function automatic word_t rd(input word_t a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  logic [CPUS-1:0] ones, ei, ed, dr;
  int   last [CPUS];
  int   prev, np, k, cnt, busy_left;
  int   mdp, mip, ew, busy, ncomp, t;
  bit   exp_d, exp_wr, pend, prev_en, en;
  word_t exp_addr, exp_store, exp_data;

  initial begin
    ones = '1;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
    nRST = 1'b0;
    nx(); nx();
    chk("rst_ren", ramREN, 0);
    chk("rst_wen", ramWEN, 0);
    chk("rst_addr", ramaddr, 0);
    chk("rst_iwait", iwait, ones);
    chk("rst_dwait", dwait, ones);
    chk("rst_loads", {iload, dload}, 0);
    nRST = 1'b1;
    nx();

    // single instruction read, RAM answers in first REQ cycle
    iREN[0] = 1'b1; iaddr[0 +: W] = 32'h100;
    nx();
    chk("t1_ren", ramREN, 1);
    chk("t1_addr", ramaddr, 32'h100);
    chk("t1_iwait_req", iwait, 2'b11);
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    nx();
    chk("t1_iwait", iwait, 2'b10);
    chk("t1_iload", fld(iload, 0), 32'hDEADBEEF);
    chk("t1_ren_off", ramREN, 0);
    iREN[0] = 1'b0; ramstate = FREE;
    nx();
    chk("t1_iwait_hi", iwait, 2'b11);
    nx();

    // data write beats simultaneous instruction read
    iREN[0] = 1'b1; iaddr[0 +: W] = 32'h300;
    dWEN[0] = 1'b1; daddr[0 +: W] = 32'h200; dstore[0 +: W] = 32'h55;
    ramstate = ACCESS; ramload = 32'h1234;
    nx();
    chk("t2_wen", ramWEN, 1);
    chk("t2_ren", ramREN, 0);
    chk("t2_addr", ramaddr, 32'h200);
    chk("t2_store", ramstore, 32'h55);
    nx();
    chk("t2_dwait", dwait, 2'b10);
    chk("t2_iwait", iwait, 2'b11);
    chk("t2_dload", fld(dload, 0), 0);
    dWEN[0] = 1'b0;
    nx();
    chk("t2_idle_ren", ramREN, 0);
    nx();
    chk("t2_i_ren", ramREN, 1);
    chk("t2_i_addr", ramaddr, 32'h300);
    nx();
    chk("t2_i_iwait", iwait, 2'b10);
    chk("t2_iload", fld(iload, 0), 32'h1234);
    iREN[0] = 1'b0;
    nx();

    // both cores stream data reads: alternate grants, 6-cycle period per core
    daddr[0 +: W] = 32'h400; daddr[W +: W] = 32'h500;
    dREN = 2'b11; ramload = 32'hAB;
    last[0] = -1; last[1] = -1; prev = -1; np = 0;
    for (int c = 0; c < 40 && np < 6; c++) begin
      nx();
      if (dwait != 2'b11) begin
        k = dwait[0] ? 1 : 0;
        chk("t3_onehot", $countones(~dwait), 1);
        chk("t3_dload", fld(dload, k), 32'hAB);
        if (prev >= 0) chk("t3_alt", k != prev, 1);
        if (last[k] >= 0) chk("t3_period", c - last[k], 6);
        last[k] = c; prev = k; np++;
      end
    end
    chk("t3_pulses", np, 6);
    dREN = '0;
    nx(); nx();

    // four BUSY cycles delay completion by four; winner's address changes ignored
    iREN[1] = 1'b1; iaddr[W +: W] = 32'h600; ramstate = BUSY; busy_left = 4;
    for (cnt = 1; cnt <= 20; cnt++) begin
      nx();
      if (!iwait[1]) break;
      if (ramREN) chk("t4_addr_hold", ramaddr, 32'h600);
      if (busy_left > 0) begin ramstate = BUSY; busy_left--; end
      else begin ramstate = ACCESS; ramload = 32'h66; end
      iaddr[W +: W] = $urandom;
    end
    chk("t4_latency", cnt, 6);
    chk("t4_iload", fld(iload, 1), 32'h66);
    iREN[1] = 1'b0; ramstate = FREE; iaddr[W +: W] = 32'h600;
    nx();

    // winner drops its request mid-REQ: abort, no pulse, pointer kept
    iaddr[0 +: W] = 32'h700; iaddr[W +: W] = 32'h780;
    iREN[0] = 1'b1; ramstate = BUSY;
    nx();
    chk("t5_ren", ramREN, 1);
    chk("t5_addr", ramaddr, 32'h700);
    iREN[0] = 1'b0;
    nx();
    chk("t5_ren_off", ramREN, 0);
    chk("t5_iwait", iwait, 2'b11);
    nx();
    chk("t5_iwait2", iwait, 2'b11);
    iREN = 2'b11; ramstate = ACCESS; ramload = 32'h77;
    nx();
    chk("t5_ptr_kept", ramaddr, 32'h700);
    nx();
    chk("t5_first", iwait, 2'b10);
    iREN[0] = 1'b0;
    nx(); nx();
    chk("t5_second_addr", ramaddr, 32'h780);
    nx();
    chk("t5_second", iwait, 2'b01);
    iREN[1] = 1'b0;
    nx();

    // reset during REQ abandons the transaction
    iaddr[W +: W] = 32'h800; iREN[1] = 1'b1; ramstate = BUSY;
    nx();
    chk("t6_ren", ramREN, 1);
    nRST = 1'b0;
    nx();
    chk("t6_rst_ren", ramREN, 0);
    chk("t6_rst_wen", ramWEN, 0);
    chk("t6_rst_addr", ramaddr, 0);
    chk("t6_rst_iwait", iwait, 2'b11);
    chk("t6_rst_dwait", dwait, 2'b11);
    nRST = 1'b1; ramstate = ACCESS; ramload = 32'h88;
    nx();
    chk("t6_again_ren", ramREN, 1);
    chk("t6_again_addr", ramaddr, 32'h800);
    nx();
    chk("t6_again_iwait", iwait, 2'b01);
    chk("t6_again_iload", fld(iload, 1), 32'h88);
    iREN[1] = 1'b0;
    nx();

    // randomized traffic against a pointer-scan model and a memory model
    nRST = 1'b0; ramstate = FREE;
    nx();
    nRST = 1'b1;
    nx();
    mdp = 0; mip = 0; pend = 0; prev_en = 0; ncomp = 0; ew = 0; busy = 0;
    exp_d = 0; exp_wr = 0; exp_addr = '0; exp_store = '0; exp_data = '0;
    for (int c = 0; c < 3000; c++) begin
      nx();
      if (pend) begin
        ei = '1; ed = '1;
        if (exp_d) ed[ew] = 1'b0; else ei[ew] = 1'b0;
        chk("rnd_iwait", iwait, ei);
        chk("rnd_dwait", dwait, ed);
        chk("rnd_load", exp_d ? fld(dload, ew) : fld(iload, ew), exp_data);
        if (exp_d) begin
          mdp = (ew + 1) % CPUS; dREN[ew] = 1'b0; dWEN[ew] = 1'b0;
        end else begin
          mip = (ew + 1) % CPUS; iREN[ew] = 1'b0;
        end
        pend = 0; ncomp++;
      end else begin
        chk("rnd_waits_idle", {iwait, dwait}, {ones, ones});
      end
      en = ramREN | ramWEN;
      if (en && !prev_en) begin
        dr = dREN | dWEN; ew = -1;
        for (int i = 0; i < CPUS; i++)
          if (ew < 0 && dr[(mdp + i) % CPUS]) begin ew = (mdp + i) % CPUS; exp_d = 1; end
        if (ew < 0)
          for (int i = 0; i < CPUS; i++)
            if (ew < 0 && iREN[(mip + i) % CPUS]) begin ew = (mip + i) % CPUS; exp_d = 0; end
        if (ew < 0) begin
          chk("rnd_spurious_grant", {dr, iREN}, 0);
          ew = 0; exp_d = 0;
        end
        exp_wr    = exp_d && dWEN[ew];
        exp_addr  = exp_d ? fld(daddr, ew) : fld(iaddr, ew);
        exp_store = exp_wr ? fld(dstore, ew) : '0;
        chk("rnd_grant_addr", ramaddr, exp_addr);
        chk("rnd_grant_wen", ramWEN, exp_wr);
        chk("rnd_grant_ren", ramREN, !exp_wr);
        chk("rnd_grant_store", ramstore, exp_store);
        busy = $urandom_range(0, 3);
      end else if (en) begin
        chk("rnd_addr_hold", ramaddr, exp_addr);
      end
      if (en) begin
        if (busy > 0) begin
          ramstate = ($urandom_range(0, 3) == 0) ? ERROR : BUSY;
          busy--;
        end else begin
          ramstate = ACCESS;
          if (exp_wr) begin
            mem[exp_addr] = exp_store; exp_data = '0; ramload = $urandom;
          end else begin
            exp_data = rd(exp_addr); ramload = exp_data;
          end
          pend = 1;
        end
        if (exp_d) begin
          daddr[ew*W +: W] = $urandom; dstore[ew*W +: W] = $urandom;
        end else begin
          iaddr[ew*W +: W] = $urandom;
        end
      end else begin
        ramstate = FREE; ramload = $urandom;
      end
      prev_en = en;
      for (int q = 0; q < CPUS; q++) begin
        if (!iREN[q] && $urandom_range(0, 3) == 0) begin
          iaddr[q*W +: W] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
          iREN[q] = 1'b1;
        end
        if (!(dREN[q] | dWEN[q]) && $urandom_range(0, 3) == 0) begin
          t = $urandom_range(0, 2);
          daddr[q*W +: W]  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
          dstore[q*W +: W] = $urandom;
          dREN[q] = (t != 1);
          dWEN[q] = (t != 0);
        end
      end
    end
    chk("rnd_progress", ncomp > 100, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
